// File: rtl/if_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_pkg
//  Description : Shared widths, constants and state encoding for the
//                instruction-fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_fetch_pkg;

    localparam int InstAddrBus = 64;
    localparam int InstBus     = 32;

    // addi x0, x0, 0
    localparam logic [InstBus-1:0] NOP_INST   = 32'h0000_0013;
    localparam logic [6:0]         JAL_OPCODE = 7'b1101111;

    typedef enum logic [1:0] {
        IF_RESET   = 2'd0,
        IF_FETCH   = 2'd1,
        IF_HOLD    = 2'd2,
        IF_DISCARD = 2'd3
    } if_state_e;

endpackage
`default_nettype wire

// File: rtl/if_jal_predecode.sv
`default_nettype none
// ============================================================================
//  Module      : if_jal_predecode
//  Description : Combinational JAL detector, J-immediate extractor and
//                target adder. Only instantiated when IF_JAL_PREDICT_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_jal_predecode
    import if_fetch_pkg::*;
(
    input  logic [InstAddrBus-1:0] i_pc,
    input  logic [6:0]             i_opcode,
    input  logic [31:12]           i_inst_hi,
    output logic                   o_is_jal,
    output logic [InstAddrBus-1:0] o_target
);

    logic [20:0] w_imm;

    // J-type immediate: imm[20|10:1|11|19:12] scattered over inst[31:12]
    assign w_imm    = {i_inst_hi[31], i_inst_hi[19:12], i_inst_hi[20],
                       i_inst_hi[30:21], 1'b0};
    assign o_is_jal = (i_opcode == JAL_OPCODE);
    assign o_target = i_pc + {{(InstAddrBus-21){w_imm[20]}}, w_imm};

endmodule
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch
//  Description : RV64 instruction-fetch stage. Owns the PC, drives a
//                valid/ack instruction-memory port, delivers {pc, inst} to
//                IF/ID and handles EX/ID redirects.
//                Optional feature macro: IF_JAL_PREDICT_EN (pre-decode JAL
//                in IF and follow its target without a bubble).
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req_o,
    output logic [InstAddrBus-1:0] imem_addr_o,
    input  logic                   imem_ack_i,
    input  logic [InstBus-1:0]     imem_rdata_i,
    input  logic                   stall_i,
    input  logic                   jalr_pc_ena_i,
    input  logic [InstAddrBus-1:0] jalr_pc_i,
    input  logic                   ex_redirect_ena_i,
    input  logic [InstAddrBus-1:0] ex_redirect_pc_i,
    output logic [InstAddrBus-1:0] pc_o,
    output logic [InstBus-1:0]     inst_o,
    output logic                   inst_valid_o,
    output logic                   if_stall_req
);

    localparam logic [InstAddrBus-1:0] c_ALIGN_MASK = ~64'd3;

    if_state_e              r_state;
    // Address of the request in flight (FETCH/DISCARD) or the next one to issue.
    logic [InstAddrBus-1:0] r_pc_next;
    // Redirect target parked while the stale request drains in DISCARD.
    logic [InstAddrBus-1:0] r_redir_pc;
    logic [InstAddrBus-1:0] r_hold_pc;
    logic [InstBus-1:0]     r_hold_inst;
    logic [InstAddrBus-1:0] r_pc_o;
    logic [InstBus-1:0]     r_inst_o;
    logic                   r_inst_valid;

    logic                   w_redir;
    logic [InstAddrBus-1:0] w_redir_pc;
    logic [InstAddrBus-1:0] w_seq_pc;
    logic [InstAddrBus-1:0] w_next_pc;

    // EX is older than ID, so its redirect wins.
    assign w_redir    = ex_redirect_ena_i | jalr_pc_ena_i;
    assign w_redir_pc = (ex_redirect_ena_i ? ex_redirect_pc_i : jalr_pc_i) & c_ALIGN_MASK;
    assign w_seq_pc   = r_pc_next + 64'd4;

`ifdef IF_JAL_PREDICT_EN
    logic                   w_jal_hit;
    logic [InstAddrBus-1:0] w_jal_target;

    if_jal_predecode u_jal_predecode (
        .i_pc      (r_pc_next),
        .i_opcode  (imem_rdata_i[6:0]),
        .i_inst_hi (imem_rdata_i[31:12]),
        .o_is_jal  (w_jal_hit),
        .o_target  (w_jal_target)
    );

    assign w_next_pc = w_jal_hit ? (w_jal_target & c_ALIGN_MASK) : w_seq_pc;
`else
    assign w_next_pc = w_seq_pc;
`endif

    // A request stays on the bus until acked, including a stale one in DISCARD.
    assign imem_req_o   = (r_state == IF_FETCH) || (r_state == IF_DISCARD);
    assign imem_addr_o  = r_pc_next & c_ALIGN_MASK;
    assign if_stall_req = imem_req_o & ~imem_ack_i;

    assign pc_o         = r_pc_o;
    assign inst_o       = r_inst_o;
    assign inst_valid_o = r_inst_valid;

    // Fetch FSM with registered IF/ID outputs; a redirect always flushes IF/ID,
    // and an unstalled cycle with nothing to deliver inserts a bubble.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IF_RESET;
            r_pc_next    <= RESET_PC;
            r_redir_pc   <= '0;
            r_hold_pc    <= '0;
            r_hold_inst  <= NOP_INST;
            r_pc_o       <= '0;
            r_inst_o     <= NOP_INST;
            r_inst_valid <= 1'b0;
        end else begin
            case (r_state)
                IF_RESET: begin
                    r_state <= IF_FETCH;
                end

                IF_FETCH: begin
                    if (w_redir) begin
                        r_inst_valid <= 1'b0;
                        r_inst_o     <= NOP_INST;
                        if (imem_ack_i) begin
                            r_pc_next <= w_redir_pc;
                        end else begin
                            r_redir_pc <= w_redir_pc;
                            r_state    <= IF_DISCARD;
                        end
                    end else if (imem_ack_i) begin
                        r_pc_next <= w_next_pc;
                        if (stall_i) begin
                            r_hold_pc   <= r_pc_next;
                            r_hold_inst <= imem_rdata_i;
                            r_state     <= IF_HOLD;
                        end else begin
                            r_pc_o       <= r_pc_next;
                            r_inst_o     <= imem_rdata_i;
                            r_inst_valid <= 1'b1;
                        end
                    end else if (!stall_i) begin
                        r_inst_valid <= 1'b0;
                        r_inst_o     <= NOP_INST;
                    end
                end

                IF_HOLD: begin
                    if (w_redir) begin
                        r_pc_next    <= w_redir_pc;
                        r_inst_valid <= 1'b0;
                        r_inst_o     <= NOP_INST;
                        r_state      <= IF_FETCH;
                    end else if (!stall_i) begin
                        r_pc_o       <= r_hold_pc;
                        r_inst_o     <= r_hold_inst;
                        r_inst_valid <= 1'b1;
                        r_state      <= IF_FETCH;
                    end
                end

                IF_DISCARD: begin
                    if (w_redir) begin
                        r_inst_valid <= 1'b0;
                        r_inst_o     <= NOP_INST;
                        r_redir_pc   <= w_redir_pc;
                        // Stale ack landing with a newer redirect: go straight to it.
                        if (imem_ack_i) begin
                            r_pc_next <= w_redir_pc;
                            r_state   <= IF_FETCH;
                        end
                    end else begin
                        if (imem_ack_i) begin
                            r_pc_next <= r_redir_pc;
                            r_state   <= IF_FETCH;
                        end
                        if (!stall_i) begin
                            r_inst_valid <= 1'b0;
                            r_inst_o     <= NOP_INST;
                        end
                    end
                end

                default: begin
                    r_state <= IF_RESET;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the RV64 five-stage pipeline. It owns the PC register and issues requests on a valid/ack instruction-memory port. It delivers `{pc, inst}` pairs to the IF/ID boundary, where the ID stage decodes them. It accepts redirects from ID (jalr misprediction) and EX (taken branch), and raises `if_stall_req` to the pipeline controller while a fetch is outstanding.

## Interface
Parameters:
- `RESET_PC`, 64'h0000_0000_8000_0000, first fetch address after reset.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset. **Synchronous and active-low:** state clears on a rising edge while `rst == 0`.
- `imem_req_o` out 1: fetch request valid.
- `imem_addr_o` out 64: fetch address; bits [1:0] always 0.
- `imem_ack_i` in 1: memory has returned data this cycle.
- `imem_rdata_i` in 32: instruction word; valid only with `imem_ack_i`.
- `stall_i` in 1: pipeline controller hold; IF/ID must not advance.
- `jalr_pc_ena_i` in 1: ID jalr redirect.
- `jalr_pc_i` in 64: ID jalr target.
- `ex_redirect_ena_i` in 1: EX taken-branch redirect.
- `ex_redirect_pc_i` in 64: EX branch target.
- `pc_o` out 64: PC of the delivered instruction.
- `inst_o` out 32: delivered instruction; 32'h0000_0013 (nop) when invalid.
- `inst_valid_o` out 1: `pc_o`/`inst_o` hold a real instruction.
- `if_stall_req` out 1: a fetch is outstanding and not yet acked.

## Operation
- State machine:
  - RESET: `rst == 0`.
  - FETCH: request asserted, waiting for ack.
  - HOLD: instruction captured, but `stall_i` is blocking delivery.
  - DISCARD: a redirect arrived while a request was outstanding; waiting for the stale ack.
- Reset:
  - `pc_next = RESET_PC`, `imem_req_o = 0`, `pc_o = 0`, `inst_o = nop`, `inst_valid_o = 0`, `if_stall_req = 0`.
  - The first cycle after release enters FETCH with `imem_addr_o = RESET_PC`.
- FETCH:
  - `imem_req_o = 1` and `if_stall_req = ~imem_ack_i`.
  - `imem_addr_o` stays stable until ack.
  - On ack with no redirect and `~stall_i`: register `pc_o`/`inst_o`, set `inst_valid_o = 1`, advance `pc_next`, and stay in FETCH. Back-to-back fetches with zero-wait memory give one instruction per cycle.
  - On ack with `stall_i`: capture into the hold register and go to HOLD.
- HOLD:
  - `imem_req_o = 0`; outputs are unchanged.
  - When `stall_i` falls, deliver the held instruction and return to FETCH at `pc_next`.
- Redirects:
  - Priority: `ex_redirect_ena_i` over `jalr_pc_ena_i` (EX is older).
  - Redirects take effect regardless of `stall_i`.
  - A redirect sets `pc_next` = target with bits [1:0] forced to 0, and sets `inst_valid_o = 0` next cycle (flushes IF/ID).
  - Redirect in FETCH with no ack that same cycle: go to DISCARD, keep `imem_req_o = 1` and the old address, and drop the data on ack.
  - Redirect in the same cycle as an ack: drop that data and refetch from the target next cycle.
  - Redirect in HOLD: drop the held instruction and go to FETCH at the target.
- DISCARD:
  - On ack, go to FETCH at the redirected `pc_next`.
  - A second redirect while in DISCARD overwrites `pc_next` and the state stays DISCARD.
- Sequential PC: `pc_next = pc + 4`, 64-bit wrap-around with no trap.
- Reset mid-fetch: an outstanding request is abandoned. Memory must tolerate a deasserted req before ack; any later ack is ignored until FETCH is re-entered.

## Timing
- Fetch-to-delivery latency:
  - Registered outputs appear one cycle after the `imem_ack_i` cycle.
  - Zero-wait memory: the first `inst_valid_o` is 2 cycles after `rst` rises.
- Redirect-to-first-request at the target: next cycle (FETCH/HOLD) or the cycle after the stale ack (DISCARD).
- `if_stall_req` is combinational from state and `imem_ack_i`. It has no path from the redirect inputs.

## Configuration
- `IF_JAL_PREDICT_EN` defined:
  - IF pre-decodes the acked word. If `inst[6:0] == 7'b1101111`, then `pc_next = pc + sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0})` instead of `pc + 4`.
  - JAL then costs no bubble.
- Undefined:
  - Always `pc + 4`.
  - JAL is resolved by EX via `ex_redirect_ena_i`.

## Structure
- Shared package/defines:
  - State encoding (`IF_RESET`, `IF_FETCH`, `IF_HOLD`, `IF_DISCARD`).
  - `NOP_INST` = 32'h0000_0013.
  - JAL opcode constant, alongside the existing `InstAddrBus`/`InstBus` widths.
- Sub-module `if_jal_predecode`: a combinational J-immediate extractor and target adder. It is instantiated only under `IF_JAL_PREDICT_EN`.

## Test plan
- Zero-wait memory returning incrementing words, with the reset release cycle as cycle 0 → `imem_addr_o` takes the values 0x8000_0000, 0x…04, and 0x…08 in cycles 1-3. Deliveries follow one cycle later, with `inst_valid_o` high continuously from cycle 2.
- Ack delayed 3 cycles → `if_stall_req = 1` for 3 cycles and `imem_addr_o` is stable. Delivery occurs the cycle after the ack.
- `stall_i` held 4 cycles across an ack → outputs are frozen and no new request is issued. After release the next address is the held PC + 4.
- `jalr_pc_ena_i = 1` and `jalr_pc_i = 0x8000_0103` mid-wait → DISCARD. The stale data is never delivered, and the next request goes to 0x8000_0100.
- `ex_redirect_ena_i` (0x8000_2000) and `jalr_pc_ena_i` (0x8000_3000) in the same cycle → the next request goes to 0x8000_2000.
- With the macro defined, fetch JAL +0x40 (word 0x0400006F) at 0x8000_0010 → the next request goes to 0x8000_0050. Without the macro it goes to 0x8000_0014.
